// File: rtl/aes_key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// aes_key_sched_ctrl
//
// Iterative AES-128 key-expansion sequencer. A 128-bit cipher key is expanded
// into 44 schedule words (11 round keys), one word per clock. A single
// combinational sub_word instance is shared and only consulted on every
// fourth word. The round keys are kept in an 11 x 128 register file and are
// read through a registered read port.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request expansion of key_in (ignored while busy)
//   key_in[127:0] in  cipher key, w0 in [127:96] ... w3 in [31:0]
//   busy         out  expansion in progress
//   done         out  one-cycle pulse after the last word is written
//   key_ready    out  full schedule in storage is valid
//   rk_rd_en     in   round-key read strobe
//   rk_addr[3:0] in   round index 0..10
//   rk_data[127:0] out round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_data_vld  out  rk_data valid, one cycle after rk_rd_en
//   dbg_state[1:0] out current sequencer state (0 = IDLE, 1 = EXPAND)
//   dbg_rcon[7:0] out current round constant register
//
// Handshake: start is a level sampled every rising edge; it is accepted only
// when the sequencer is IDLE. rk_rd_en is a one-cycle request with no
// back-pressure; every accepted request yields rk_data_vld exactly one cycle
// later.
// -----------------------------------------------------------------------------

// Combinational SubWord: four parallel AES S-box lookups, one per byte lane.
module sub_word (
    input  logic [31:0] in,
    output logic [31:0] out
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out = {SBOX[in[31:24]], SBOX[in[23:16]], SBOX[in[15:8]], SBOX[in[7:0]]};
endmodule

module aes_key_sched_ctrl #(
    parameter int NR = 10,
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         rk_data_vld,
    output logic [1:0]   dbg_state,
    output logic [7:0]   dbg_rcon
);
    localparam int NWORDS = NK * (NR + 1);      // 44 schedule words
    localparam int NSLOTS = NR + 1;             // 11 round keys

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1
    } state_t;

    state_t       state;
    logic [5:0]   idx;                          // index of the word being produced
    logic [7:0]   rcon;
    logic [31:0]  win [4];                      // win[0] = w[i-4] ... win[3] = w[i-1]
    logic [127:0] rf  [NSLOTS];

    logic [31:0]  rot_w;
    logic [31:0]  sub_out;
    logic [31:0]  temp_w;
    logic [31:0]  new_w;
    logic         sub_cycle;
    logic [7:0]   rcon_next;

    // RotWord of the most recent word feeds the shared S-box.
    assign rot_w = {win[3][23:0], win[3][31:24]};

    sub_word u_sub_word (
        .in  (rot_w),
        .out (sub_out)
    );

    assign sub_cycle = (idx[1:0] == 2'd0);
    assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

    always_comb begin
        temp_w = win[3];
        if (sub_cycle) begin
            temp_w = sub_out ^ {rcon, 24'h0};
        end
        new_w = win[0] ^ temp_w;
    end

    assign dbg_state = state;
    assign dbg_rcon  = rcon;

    // Sequencer, schedule storage and sliding word window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= 6'd0;
            rcon      <= 8'h01;
            busy      <= 1'b0;
            done      <= 1'b0;
            key_ready <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                win[i] <= 32'h0;
            end
            for (int s = 0; s < NSLOTS; s++) begin
                rf[s] <= 128'h0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rf[0]     <= key_in;
                        win[0]    <= key_in[127:96];
                        win[1]    <= key_in[95:64];
                        win[2]    <= key_in[63:32];
                        win[3]    <= key_in[31:0];
                        idx       <= 6'd4;
                        rcon      <= 8'h01;
                        busy      <= 1'b1;
                        key_ready <= 1'b0;
                        state     <= EXPAND;
                    end
                end
                EXPAND: begin
                    case (idx[1:0])
                        2'd0: rf[idx[5:2]][127:96] <= new_w;
                        2'd1: rf[idx[5:2]][95:64]  <= new_w;
                        2'd2: rf[idx[5:2]][63:32]  <= new_w;
                        default: rf[idx[5:2]][31:0] <= new_w;
                    endcase
                    win[0] <= win[1];
                    win[1] <= win[2];
                    win[2] <= win[3];
                    win[3] <= new_w;
                    // The last rcon use (word 40) leaves 0x36 in place.
                    if (sub_cycle && (idx != 6'(NWORDS - 4))) begin
                        rcon <= rcon_next;
                    end
                    if (idx == 6'(NWORDS - 1)) begin
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        key_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Registered read port. Because storage is updated with non-blocking
    // assignments, a read of a slot being written this cycle sees old data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_data     <= 128'h0;
            rk_data_vld <= 1'b0;
        end else begin
            rk_data_vld <= rk_rd_en;
            if (rk_rd_en) begin
                if (rk_addr <= 4'(NR)) begin
                    rk_data <= rf[rk_addr];
                end else begin
                    rk_data <= 128'h0;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         rk_rd_en;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rk_data_vld;
    logic [1:0]   dbg_state;
    logic [7:0]   dbg_rcon;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] KEY_X  = 128'hffeeddccbbaa99887766554433221100;

    // clock / reset
    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .key_ready   (key_ready),
        .rk_rd_en    (rk_rd_en),
        .rk_addr     (rk_addr),
        .rk_data     (rk_data),
        .rk_data_vld (rk_data_vld),
        .dbg_state   (dbg_state),
        .dbg_rcon    (dbg_rcon)
    );

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
    endtask

    // Counts edges (the launch edge counts as 1) until done is seen; 0 on timeout.
    task automatic wait_done(output int n);
        int c;
        c = 1;
        n = 0;
        while (c < 100) begin
            tick();
            c++;
            if (done) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d, output logic v);
        rk_rd_en = 1'b1;
        rk_addr  = a;
        tick();
        rk_rd_en = 1'b0;
        d = rk_data;
        v = rk_data_vld;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if ({busy, done, key_ready, rk_data_vld} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, key_ready, rk_data_vld});
        end
        total++;
        if (rk_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_rk_data: got %h want 0", rk_data);
        end
        total++;
        if (dbg_state !== 2'd0 || dbg_rcon !== 8'h01) begin
            bad++;
            $display("FAIL reset_state_rcon: got %0d/%h want 0/01", dbg_state, dbg_rcon);
        end
    endtask

    task automatic test_fips_a1();
        int n;
        logic [127:0] d;
        logic v;
        launch(KEY_A);
        total++;
        if (busy !== 1'b1 || key_ready !== 1'b0) begin
            bad++;
            $display("FAIL a1_busy_after_start: got busy=%b key_ready=%b want 1 0", busy, key_ready);
        end
        wait_done(n);
        total++;
        if (n != 41) begin
            bad++;
            $display("FAIL a1_latency: got %0d want 41", n);
        end
        total++;
        if (busy !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL a1_done_flags: got busy=%b key_ready=%b want 0 1", busy, key_ready);
        end
        tick();
        total++;
        if (done !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL a1_done_pulse: got done=%b key_ready=%b want 0 1", done, key_ready);
        end
        read_rk(4'd0, d, v);
        total++;
        if (d !== KEY_A || v !== 1'b1) begin
            bad++;
            $display("FAIL a1_rk0: got %h vld=%b want %h vld=1", d, v, KEY_A);
        end
        read_rk(4'd1, d, v);
        total++;
        if (d !== A_RK1) begin
            bad++;
            $display("FAIL a1_rk1: got %h want %h", d, A_RK1);
        end
        read_rk(4'd2, d, v);
        total++;
        if (d !== A_RK2) begin
            bad++;
            $display("FAIL a1_rk2: got %h want %h", d, A_RK2);
        end
        read_rk(4'd10, d, v);
        total++;
        if (d !== A_RK10) begin
            bad++;
            $display("FAIL a1_rk10: got %h want %h", d, A_RK10);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [127:0] d;
        logic v;
        launch(KEY_A);
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busy, key_ready, done} !== 3'b000) begin
            bad++;
            $display("FAIL mid_reset_flags: got %b want 000", {busy, key_ready, done});
        end
        for (int a = 0; a <= 10; a++) begin
            read_rk(4'(a), d, v);
            total++;
            if (d !== 128'h0 || v !== 1'b1) begin
                bad++;
                $display("FAIL mid_reset_read%0d: got %h vld=%b want 0 vld=1", a, d, v);
            end
        end
        launch(KEY_A);
        wait_done(n);
        total++;
        if (n != 41) begin
            bad++;
            $display("FAIL mid_reset_relatency: got %0d want 41", n);
        end
        read_rk(4'd10, d, v);
        total++;
        if (d !== A_RK10) begin
            bad++;
            $display("FAIL mid_reset_rk10: got %h want %h", d, A_RK10);
        end
    endtask

    task automatic test_start_while_busy();
        int dones;
        logic [127:0] d;
        logic v;
        dones = 0;
        launch(KEY_A);
        for (int k = 1; k <= 60; k++) begin
            start  = (k < 35) && (k % 3 == 0);
            key_in = KEY_X;
            tick();
            if (done) dones++;
        end
        start = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL busy_start_done_count: got %0d want 1", dones);
        end
        read_rk(4'd10, d, v);
        total++;
        if (d !== A_RK10) begin
            bad++;
            $display("FAIL busy_start_rk10: got %h want %h", d, A_RK10);
        end
        read_rk(4'd0, d, v);
        total++;
        if (d !== KEY_A) begin
            bad++;
            $display("FAIL busy_start_rk0: got %h want %h", d, KEY_A);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] d;
        logic v;
        launch(KEY_A);
        wait_done(n);
        total++;
        if (n != 41) begin
            bad++;
            $display("FAIL b2b_first_latency: got %0d want 41", n);
        end
        // start raised during the done cycle
        launch(KEY_B);
        total++;
        if ({busy, key_ready, done} !== 3'b100) begin
            bad++;
            $display("FAIL b2b_accept: got %b want 100", {busy, key_ready, done});
        end
        wait_done(n);
        total++;
        if (n != 41) begin
            bad++;
            $display("FAIL b2b_second_latency: got %0d want 41", n);
        end
        read_rk(4'd10, d, v);
        total++;
        if (d !== B_RK10) begin
            bad++;
            $display("FAIL b2b_rk10: got %h want %h", d, B_RK10);
        end
        read_rk(4'd0, d, v);
        total++;
        if (d !== KEY_B) begin
            bad++;
            $display("FAIL b2b_rk0: got %h want %h", d, KEY_B);
        end
    endtask

    task automatic test_read_port();
        int n;
        logic [127:0] d;
        logic v;
        launch(KEY_A);
        wait_done(n);
        read_rk(4'd11, d, v);
        total++;
        if (d !== 128'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL read_addr11: got %h vld=%b want 0 vld=1", d, v);
        end
        read_rk(4'd15, d, v);
        total++;
        if (d !== 128'h0 || v !== 1'b1) begin
            bad++;
            $display("FAIL read_addr15: got %h vld=%b want 0 vld=1", d, v);
        end
        read_rk(4'd1, d, v);
        rk_addr = 4'd10;
        tick();
        total++;
        if (rk_data_vld !== 1'b0 || rk_data !== A_RK1) begin
            bad++;
            $display("FAIL read_hold: got %h vld=%b want %h vld=0", rk_data, rk_data_vld, A_RK1);
        end
    endtask

    task automatic test_rcon();
        logic [7:0] exp_rc [10];
        logic [7:0] seen [42];
        int n;
        exp_rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        launch(KEY_A);
        seen[1] = dbg_rcon;
        for (int c = 2; c <= 41; c++) begin
            tick();
            seen[c] = dbg_rcon;
        end
        // word 4+4j is produced in the cycle sampled as index 1+4j
        for (int j = 0; j < 10; j++) begin
            total++;
            if (seen[1 + 4 * j] !== exp_rc[j]) begin
                bad++;
                $display("FAIL rcon_%0d: got %h want %h", j, seen[1 + 4 * j], exp_rc[j]);
            end
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL rcon_done_cycle: got %b want 1", done);
        end
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (dbg_rcon !== 8'h36) begin
            bad++;
            $display("FAIL rcon_frozen: got %h want 36", dbg_rcon);
        end
        launch(KEY_B);
        total++;
        if (dbg_rcon !== 8'h01) begin
            bad++;
            $display("FAIL rcon_reload: got %h want 01", dbg_rcon);
        end
        wait_done(n);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = 128'h0;
        rk_rd_en = 1'b0;
        rk_addr  = 4'd0;
        test_reset();
        test_fips_a1();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        test_read_port();
        test_rcon();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Iterative AES-128 key-expansion sequencer.
- Accepts a 128-bit cipher key and produces all 44 schedule words (11 round keys), one word per clock.
- Time-shares a single sub_word instance, exercised only on every fourth word.
- Stores the round keys in an internal 11x128 register file; the round datapath reads them through a registered read port.

Parameters:
- NR, 10, number of rounds (fixed for AES-128; only 10 supported).
- NK, 4, key length in 32-bit words (fixed at 4).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request expansion of key_in; sampled each cycle.
- key_in  input  128  cipher key; key_in[127:96] = w0, key_in[31:0] = w3.
- busy  output  1  expansion in progress.
- done  output  1  one-cycle pulse when the last word is written.
- key_ready  output  1  the full schedule in storage is valid.
- rk_rd_en  input  1  round-key read strobe.
- rk_addr  input  4  round index 0..10.
- rk_data  output  128  round key; {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in the MSBs.
- rk_data_vld  output  1  rk_data valid; one cycle after rk_rd_en.

Behaviour:
Reset (rst=1 at a clock edge):
- State goes to IDLE.
- busy, done, key_ready, rk_data_vld = 0; rk_data = 0.
- Register file is cleared to 0; word counter = 0; rcon = 8'h01.
- A reset mid-expansion aborts the expansion; key_ready stays 0.

Word convention:
- Byte0 of a word is bits [31:24].
- RotWord(w) = {w[23:0], w[31:24]}.
- Rcon is XORed into bits [31:24].
- Bytes presented to sub_word: in = RotWord(w[i-1]), byte-for-byte; the S-box is bytewise, so lane ordering only has to be consistent.

State machine:
- IDLE:
  - start=1 in cycle T loads w0..w3 from key_in into slot 0.
  - Sets idx=4, key_ready=0, busy=1 from T+1, goes to EXPAND.
- EXPAND: each cycle computes one word, writes it into slot idx/4 at lane idx%4, then idx++.
  - idx%4==0: w[i] = w[i-4] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; rcon then advances by xtime (0x80 -> 0x1B -> 0x36).
  - Otherwise: w[i] = w[i-4] ^ w[i-1].
  - w[i-1] and w[i-4] are held in a 4-word sliding register, not read back from storage.
  - After idx=43 is written (cycle T+40), go to IDLE.
  - At T+41: busy=0, key_ready=1, done=1 for that single cycle.
- Latency: start to done = 41 cycles.
- start while busy: ignored. No queuing, no restart.
- start in IDLE with key_ready=1: re-expands; key_ready drops to 0 on the following cycle.
- start asserted in the same cycle that done pulses: accepted (state is IDLE).

Read port:
- rk_rd_en=1 in cycle C: rk_data = slot[rk_addr] and rk_data_vld=1 in C+1; otherwise rk_data_vld=0 and rk_data holds its last value.
- rk_addr > 10: rk_data = 0, rk_data_vld still 1.
- Reads during busy are permitted and return the current (partial) storage.
- A read of the slot being written in the same cycle returns the old contents.

Combinational sub_word:
- sub_word is instantiated once; its output is used only in the idx%4==0 cycle, with no extra pipeline stage.

Test Plan:
1. FIPS-197 A.1: rst, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> done exactly 41 cycles after start. Reading rk_addr=1 gives a0fafe1788542cb123a339392a6c7605; rk_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; rk_addr=0 returns key_in.
2. Reset mid-expansion: assert rst at cycle 20 after start -> busy=0, key_ready=0, all reads return 0. A fresh start then completes correctly in 41 cycles.
3. start pulsed repeatedly while busy with a different key -> ignored; the schedule matches the first key; done pulses exactly once.
4. Back-to-back: start asserted in the done cycle with key 000102030405060708090a0b0c0d0e0f -> new expansion. rk_addr=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
5. Read port: rk_rd_en with rk_addr=11 and 15 -> rk_data_vld=1, rk_data=0. rk_rd_en=0 -> rk_data_vld=0, rk_data held.
6. Rcon sequence: monitor rcon over the 10 SubWord cycles -> 01,02,04,08,10,20,40,80,1B,36; afterwards rcon stays frozen until the next start reloads it to 01.
